reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 156 +++++++++++++++
 tb/tb_reaction_timer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction timer: debounced key, light-sequence FSM, ms counter with saturation at MAX_MS.
// Optional BEST_TIME_EN macro adds a best_ms output tracking the fastest non-jump reaction.
//
// state  | meaning
// IDLE   | waiting for the first arm after reset
// ARMED  | lights sequence running; a press here is a jump start
// TIMING | lights out, counting ms until press or MAX_MS
// DONE   | result latched, held until next arm
// JUMP   | jump start latched, held until next arm
module reaction_timer #(
  parameter int unsigned MAX_MS = 9999,
  parameter int unsigned DEB_MS = 3
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic        tick_ms,
  input  logic        arm,
  input  logic        lights_out,
  input  logic        key_n,
  output logic [13:0] react_ms,
  output logic        valid,
  output logic        jump,
  output logic        busy
`ifdef BEST_TIME_EN
  ,
  output logic [13:0] best_ms
`endif
);

  localparam int unsigned DW = (DEB_MS < 2) ? 1 : $clog2(DEB_MS + 1);
  localparam logic [DW-1:0] DEB_FULL = DW'(DEB_MS);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MS - 1);
  localparam logic [13:0]   MAX_V    = 14'(MAX_MS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    JUMP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          key_s1_q, key_s1_d;
  logic          key_s2_q, key_s2_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [13:0]   count_q, count_d;
  logic [13:0]   react_q, react_d;
  logic          valid_q, valid_d;
  logic          jump_q, jump_d;
  logic          press_evt;
  logic [13:0]   count_inc;
`ifdef BEST_TIME_EN
  logic [13:0]   best_q, best_d;
`endif

  // Debounce: counter saturates at DEB_MS, which also blocks re-triggering until release.
  always_comb begin
    key_s1_d  = key_n;
    key_s2_d  = key_s1_q;
    deb_d     = deb_q;
    press_evt = 1'b0;
    if (key_s2_q) begin
      deb_d = '0;
    end else if (tick_ms && (deb_q != DEB_FULL)) begin
      deb_d     = deb_q + 1'b1;
      press_evt = (deb_q == DEB_LAST);
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    react_d   = react_q;
    valid_d   = 1'b0;
    jump_d    = jump_q;
    count_inc = count_q + 14'd1;
`ifdef BEST_TIME_EN
    best_d    = best_q;
`endif
    if (arm) begin
      state_d = ARMED;
      jump_d  = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (press_evt) begin
            state_d = JUMP;
            jump_d  = 1'b1;
            valid_d = 1'b1;
          end else if (lights_out) begin
            state_d = TIMING;
            count_d = '0;
          end
        end
        TIMING: begin
          // A press on the same tick reports the count before that tick.
          if (press_evt) begin
            state_d = DONE;
            react_d = count_q;
            valid_d = 1'b1;
`ifdef BEST_TIME_EN
            if (count_q < best_q) best_d = count_q;
`endif
          end else if (tick_ms) begin
            count_d = count_inc;
            if (count_inc >= MAX_V) begin
              state_d = DONE;
              react_d = MAX_V;
              valid_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      deb_q    <= '0;
      count_q  <= '0;
      react_q  <= '0;
      valid_q  <= 1'b0;
      jump_q   <= 1'b0;
`ifdef BEST_TIME_EN
      best_q   <= MAX_V;
`endif
    end else begin
      state_q  <= state_d;
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      deb_q    <= deb_d;
      count_q  <= count_d;
      react_q  <= react_d;
      valid_q  <= valid_d;
      jump_q   <= jump_d;
`ifdef BEST_TIME_EN
      best_q   <= best_d;
`endif
    end
  end

  assign react_ms = react_q;
  assign valid    = valid_q;
  assign jump     = jump_q;
  assign busy     = (state_q == ARMED) || (state_q == TIMING);
`ifdef BEST_TIME_EN
  assign best_ms  = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: stimulus pushes expected results, a negedge monitor checks each valid.
module tb_reaction_timer;

  logic        CLOCK_50 = 1'b0;
  logic        RST_N = 1'b0;
  logic        tick_ms = 1'b0;
  logic        arm = 1'b0;
  logic        lights_out = 1'b0;
  logic        key_n = 1'b1;
  logic [13:0] react_ms;
  logic        valid;
  logic        jump;
  logic        busy;
`ifdef BEST_TIME_EN
  logic [13:0] best_ms;
`endif

  typedef struct {
    logic [13:0] react;
    logic        jump;
    logic [13:0] best;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [13:0] exp_best = 14'd9999;

  reaction_timer dut (
    .CLOCK_50  (CLOCK_50),
    .RST_N     (RST_N),
    .tick_ms   (tick_ms),
    .arm       (arm),
    .lights_out(lights_out),
    .key_n     (key_n),
    .react_ms  (react_ms),
    .valid     (valid),
    .jump      (jump),
    .busy      (busy)
`ifdef BEST_TIME_EN
    ,
    .best_ms   (best_ms)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (RST_N && valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: react_ms=%0d jump=%0d", react_ms, jump);
      end else begin
        exp_t e;
        logic bad;
        e = sb_q.pop_front();
        bad = (react_ms !== e.react) || (jump !== e.jump) || (busy !== 1'b0);
`ifdef BEST_TIME_EN
        bad = bad || (best_ms !== e.best);
`endif
        if (bad) begin
          n_err++;
          $display("FAIL result: got react=%0d jump=%0d busy=%0d, want react=%0d jump=%0d busy=0",
                   react_ms, jump, busy, e.react, e.jump);
`ifdef BEST_TIME_EN
          $display("FAIL result_best: got best=%0d want best=%0d", best_ms, e.best);
`endif
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_ms = 1'b1;
      step(1);
      tick_ms = 1'b0;
      step(3);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    step(1);
  endtask

  task automatic pulse_lights();
    lights_out = 1'b1;
    step(1);
    lights_out = 1'b0;
    step(1);
  endtask

  // Press held through DEB_MS=3 ticks; two of those ticks still advance the count.
  task automatic press();
    key_n = 1'b0;
    step(3);
    ticks(3);
    key_n = 1'b1;
    step(3);
  endtask

  task automatic expect_result(input logic [13:0] r, input logic j);
    exp_t e;
    e.react = r;
    e.jump  = j;
    e.best  = exp_best;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected valid pulse(s) never seen", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(2);
  endtask

  initial begin
    #1;
    chk("rst_react", react_ms, 14'd0);
    chk("rst_valid", {13'd0, valid}, 14'd0);
    chk("rst_jump", {13'd0, jump}, 14'd0);
    chk("rst_busy", {13'd0, busy}, 14'd0);
`ifdef BEST_TIME_EN
    chk("rst_best", best_ms, 14'd9999);
`endif
    step(2);
    RST_N = 1'b1;
    step(2);

    // lights_out in IDLE is ignored
    pulse_lights();
    chk("idle_lights_busy", {13'd0, busy}, 14'd0);

    // normal round: 250 ticks then a debounced press -> 252
    pulse_arm();
    chk("armed_busy", {13'd0, busy}, 14'd1);
    pulse_lights();
    ticks(250);
    exp_best = 14'd252;
    expect_result(14'd252, 1'b0);
    press();
    drain("round_252");
    chk("done_busy", {13'd0, busy}, 14'd0);
    chk("done_react_hold", react_ms, 14'd252);

    // jump start: press before lights_out, later lights_out ignored
    pulse_arm();
    expect_result(14'd252, 1'b1);
    press();
    drain("jump");
    pulse_lights();
    ticks(5);
    chk("jump_level", {13'd0, jump}, 14'd1);
    chk("jump_busy", {13'd0, busy}, 14'd0);
    chk("jump_react_hold", react_ms, 14'd252);

    // arm clears jump without a valid
    pulse_arm();
    chk("arm_clears_jump", {13'd0, jump}, 14'd0);

    // 2-tick glitch is rejected; real press later -> 10+2+8+2 = 22
    pulse_lights();
    ticks(10);
    key_n = 1'b0;
    step(3);
    ticks(2);
    key_n = 1'b1;
    step(3);
    ticks(8);
    chk("glitch_still_busy", {13'd0, busy}, 14'd1);
    exp_best = 14'd22;
    expect_result(14'd22, 1'b0);
    press();
    drain("glitch_round_22");

    // timeout at MAX_MS
    pulse_arm();
    pulse_lights();
    ticks(9998);
    chk("pre_timeout_busy", {13'd0, busy}, 14'd1);
    expect_result(14'd9999, 1'b0);
    ticks(1);
    drain("timeout");
    chk("timeout_busy", {13'd0, busy}, 14'd0);
    chk("timeout_react", react_ms, 14'd9999);

    // reset mid-round at count 100
    pulse_arm();
    pulse_lights();
    ticks(100);
    RST_N = 1'b0;
    #1;
    chk("midrst_react", react_ms, 14'd0);
    chk("midrst_busy", {13'd0, busy}, 14'd0);
    chk("midrst_valid", {13'd0, valid}, 14'd0);
    exp_best = 14'd9999;
`ifdef BEST_TIME_EN
    chk("midrst_best", best_ms, 14'd9999);
`endif
    step(2);
    RST_N = 1'b1;
    step(2);
    pulse_lights();
    chk("post_rst_idle", {13'd0, busy}, 14'd0);
    pulse_arm();
    pulse_lights();
    ticks(40);
    exp_best = 14'd42;
    expect_result(14'd42, 1'b0);
    press();
    drain("post_rst_round_42");

    // arm during TIMING restarts the count; result 10+2 = 12
    pulse_arm();
    pulse_lights();
    ticks(50);
    pulse_arm();
    chk("rearm_react_kept", react_ms, 14'd42);
    pulse_lights();
    ticks(10);
    exp_best = 14'd12;
    expect_result(14'd12, 1'b0);
    press();
    drain("rearm_round_12");

`ifdef BEST_TIME_EN
    do_reset();
    exp_best = 14'd9999;
    pulse_arm(); pulse_lights(); ticks(298);
    exp_best = 14'd300;
    expect_result(14'd300, 1'b0);
    press();
    drain("best_300");
    chk("best_after_300", best_ms, 14'd300);
    pulse_arm(); pulse_lights(); ticks(178);
    exp_best = 14'd180;
    expect_result(14'd180, 1'b0);
    press();
    drain("best_180");
    chk("best_after_180", best_ms, 14'd180);
    pulse_arm(); pulse_lights(); ticks(218);
    expect_result(14'd220, 1'b0);
    press();
    drain("best_220");
    chk("best_after_220", best_ms, 14'd180);
    pulse_arm();
    expect_result(14'd220, 1'b1);
    press();
    drain("best_jump");
    chk("best_after_jump", best_ms, 14'd180);
`endif

    step(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
